rx_sampler: RTL and testbench

RX_SAMPLER -- requirements
Module: rx_sampler

---
 rtl/rx_sampler_pkg.sv | 33 +++
 rtl/rx_sampler_if.sv | 26 ++
 rtl/bbpd.sv | 18 +
 rtl/rx_sampler.sv | 134 +++++++++++++
 tb/tb_rx_sampler.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/rx_sampler_pkg.sv
// Shared formats, loop-filter defaults and FSM encoding for the rx_sampler slice.
// Time/step/filter widths live here so every file agrees on them.
package rx_sampler_pkg;

  localparam int TIME_WIDTH       = 32;
  localparam int DT_WIDTH         = 16;
  localparam int FILTER_OUT_WIDTH = 16;
  localparam int INTEG_WIDTH      = 8;

  localparam int SMP_UI_NOM = 1000;
  localparam int SMP_UI_MIN = 900;
  localparam int SMP_UI_MAX = 1100;
  localparam int SMP_KP     = 4;
  localparam int SMP_KI_LIM = 8;
  localparam int SMP_THRESH = 0;

  typedef logic        [TIME_WIDTH-1:0]       time_t;
  typedef logic        [DT_WIDTH-1:0]         dt_t;
  typedef logic signed [FILTER_OUT_WIDTH-1:0] filt_t;
  typedef logic signed [INTEG_WIDTH-1:0]      integ_t;

  typedef enum logic {
    ST_EDGE = 1'b0,
    ST_DATA = 1'b1
  } smp_state_e;

  // Clamp a modular time difference to the largest representable step.
  function automatic dt_t sat_dt(input time_t d);
    if (|d[TIME_WIDTH-1:DT_WIDTH]) return '1;
    return d[DT_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/rx_sampler_if.sv
// Filter-side sample bus of the rx_sampler: time/filter inputs, step request and sliced outputs.
interface rx_sampler_if;
  import rx_sampler_pkg::*;

  filt_t in;
  time_t time_next;
  dt_t   dt_req;
  logic  time_eq_out;
  logic  data_bit;
  logic  data_valid;
  logic  early;
  logic  late;
  dt_t   period;
  logic  miss;

  modport master (
    output in, time_next,
    input  dt_req, time_eq_out, data_bit, data_valid, early, late, period, miss
  );

  modport slave (
    input  in, time_next,
    output dt_req, time_eq_out, data_bit, data_valid, early, late, period, miss
  );

endinterface

// File: rtl/bbpd.sv
// bbpd: Alexander bang-bang phase detector over previous data, edge and current data samples.
// Combinational; decisions are only produced while strobe is high.
module bbpd (
  input  logic prev_d,
  input  logic edge_s,
  input  logic cur_d,
  input  logic strobe,
  output logic early,
  output logic late
);

  logic trans;

  assign trans = strobe && (prev_d != cur_d);
  assign early = trans && (edge_s == prev_d);
  assign late  = trans && (edge_s == cur_d);

endmodule

// File: rtl/rx_sampler.sv
// rx_sampler: bang-bang CDR scheduling edge/data sample instants in emulated time.
// Latency: event in cycle N -> data_valid/early/late in N+2; no backpressure, outputs are strobes/levels.
module rx_sampler
  import rx_sampler_pkg::*;
#(
  parameter int UI_NOM = SMP_UI_NOM,
  parameter int UI_MIN = SMP_UI_MIN,
  parameter int UI_MAX = SMP_UI_MAX,
  parameter int KP     = SMP_KP,
  parameter int KI_LIM = SMP_KI_LIM,
  parameter int THRESH = SMP_THRESH
) (
  input logic         clk_sys,
  input logic         rst_n,
  rx_sampler_if.slave sio
);

  smp_state_e state_q, state_d;
  time_t      t_target_q, t_target_d;
  time_t      ahead, kp_adj, step;
  dt_t        period_q, period_d, half, rest;
  integ_t     integ_q, integ_d, integ_sum;

  logic pending_q, pend_data_q;
  logic prev_d_q, edge_s_q;
  logic data_bit_q, data_valid_q, early_q, late_q;
  logic last_early_q, last_late_q;
  logic miss_q;
  logic time_eq, miss_now, cur_bit, data_slice, pd_early, pd_late;

  assign half    = period_q >> 1;
  assign rest    = period_q - half;
  assign time_eq = (sio.time_next == t_target_q);
  assign ahead   = sio.time_next - t_target_q;
  // Non-equal and a non-negative modular difference means the target was skipped over.
  assign miss_now   = !time_eq && !ahead[TIME_WIDTH-1];
  assign cur_bit    = (sio.in >= filt_t'(THRESH));
  assign data_slice = pending_q && pend_data_q;

  bbpd u_bbpd (
    .prev_d (prev_d_q),
    .edge_s (edge_s_q),
    .cur_d  (cur_bit),
    .strobe (data_slice),
    .early  (pd_early),
    .late   (pd_late)
  );

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) state_q <= ST_EDGE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (time_eq) state_d = (state_q == ST_EDGE) ? ST_DATA : ST_EDGE;
  end

  always_comb begin
    kp_adj = '0;
    if (last_early_q)     kp_adj = time_t'(KP);
    else if (last_late_q) kp_adj = -time_t'(KP);
    step = (state_q == ST_EDGE) ? time_t'(half) : time_t'(rest) + kp_adj;
    t_target_d = t_target_q;
    if (time_eq)       t_target_d = t_target_q + step;
    else if (miss_now) t_target_d = sio.time_next + time_t'(half);
  end

  // Integral path: KI_LIM same-sign decisions nudge the period by one LSB.
  always_comb begin
    integ_sum = integ_q;
    if (pd_early)     integ_sum = integ_q + integ_t'(1);
    else if (pd_late) integ_sum = integ_q - integ_t'(1);
    integ_d  = integ_q;
    period_d = period_q;
    if (data_slice) begin
      integ_d = integ_sum;
      if (integ_sum >= integ_t'(KI_LIM)) begin
        integ_d  = '0;
        period_d = (period_q > dt_t'(UI_MIN)) ? period_q - dt_t'(1) : dt_t'(UI_MIN);
      end else if (integ_sum <= -integ_t'(KI_LIM)) begin
        integ_d  = '0;
        period_d = (period_q < dt_t'(UI_MAX)) ? period_q + dt_t'(1) : dt_t'(UI_MAX);
      end
    end
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      t_target_q   <= '0;
      period_q     <= dt_t'(UI_NOM);
      integ_q      <= '0;
      pending_q    <= 1'b0;
      pend_data_q  <= 1'b0;
      prev_d_q     <= 1'b0;
      edge_s_q     <= 1'b0;
      data_bit_q   <= 1'b0;
      data_valid_q <= 1'b0;
      early_q      <= 1'b0;
      late_q       <= 1'b0;
      last_early_q <= 1'b0;
      last_late_q  <= 1'b0;
      miss_q       <= 1'b0;
    end else begin
      t_target_q   <= t_target_d;
      period_q     <= period_d;
      integ_q      <= integ_d;
      pending_q    <= time_eq;
      pend_data_q  <= time_eq && (state_q == ST_DATA);
      miss_q       <= miss_q || miss_now;
      data_valid_q <= data_slice;
      early_q      <= pd_early;
      late_q       <= pd_late;
      if (data_slice) begin
        data_bit_q   <= cur_bit;
        prev_d_q     <= cur_bit;
        last_early_q <= pd_early;
        last_late_q  <= pd_late;
      end else if (pending_q) begin
        edge_s_q <= cur_bit;
      end
    end
  end

  assign sio.dt_req      = sat_dt(t_target_d - sio.time_next);
  assign sio.time_eq_out = time_eq;
  assign sio.data_bit    = data_bit_q;
  assign sio.data_valid  = data_valid_q;
  assign sio.early       = early_q;
  assign sio.late        = late_q;
  assign sio.period      = period_q;
  assign sio.miss        = miss_q;

endmodule

// File: tb/tb_rx_sampler.sv
// Randomized scoreboard bench for rx_sampler against an event-level reference model.
module tb_rx_sampler;
  import rx_sampler_pkg::*;

  localparam int KP     = 4;
  localparam int KI     = 8;
  localparam int UMIN   = 900;
  localparam int UMAX   = 1100;
  localparam int UNOM   = 1000;
  localparam logic [31:0] SAFE_T = 32'hFFF0_0000;

  logic clk_sys = 1'b0;
  logic rst_n   = 1'b1;

  rx_sampler_if sio ();

  rx_sampler #(
    .UI_NOM(UNOM), .UI_MIN(UMIN), .UI_MAX(UMAX), .KP(KP), .KI_LIM(KI), .THRESH(0)
  ) dut (
    .clk_sys (clk_sys),
    .rst_n   (rst_n),
    .sio     (sio)
  );

  always #5 clk_sys = ~clk_sys;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic b;
    logic e;
    logic l;
  } exp_t;
  exp_t exp_q[$];

  // Reference model state (values as visible to the outside after each edge).
  logic [31:0] m_tgt;
  logic [31:0] t_cur;
  int          m_per;
  int          m_int;
  bit          m_data, m_prev, m_edge, m_pend, m_pend_data, m_le, m_ll, m_miss;
  int          mode;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_tgt = '0; m_per = UNOM; m_int = 0; m_data = 0; m_prev = 0; m_edge = 0;
    m_pend = 0; m_pend_data = 0; m_le = 0; m_ll = 0; m_miss = 0;
  endtask

  function automatic logic signed [15:0] drive_level(input bit want);
    if (want) return 16'(int'($urandom_range(0, 300)));
    return 16'(-int'($urandom_range(1, 300)));
  endfunction

  function automatic logic signed [15:0] pick_in();
    int r;
    if (!m_pend) return 16'(int'($urandom_range(0, 200)) - 100);
    case (mode)
      1: return drive_level(m_pend_data ? !m_prev : m_prev);
      2: return 16'sd5;
      3: return drive_level(!m_prev);
      default: begin
        r = int'($urandom_range(0, 9));
        case (r)
          0: return 16'sd0;
          1: return -16'sd1;
          2: return 16'sh7FFF;
          3: return 16'sh8000;
          default: return 16'(int'($urandom_range(0, 20)) - 10);
        endcase
      end
    endcase
  endfunction

  task automatic cycle(input logic [31:0] t);
    logic signed [15:0] v;
    logic [31:0] ntgt, dtf;
    int half, adj, exp_dt;
    bit eq, ms, b, e, l;
    @(posedge clk_sys);
    #1;
    v = pick_in();
    sio.time_next = t;
    sio.in = v;
    t_cur = t;
    #3;
    half = m_per / 2;
    adj  = m_le ? KP : (m_ll ? -KP : 0);
    eq   = (t == m_tgt);
    ms   = !eq && ($signed(t - m_tgt) > 0);
    if (eq)      ntgt = m_data ? m_tgt + 32'(m_per - half + adj) : m_tgt + 32'(half);
    else if (ms) ntgt = t + 32'(half);
    else         ntgt = m_tgt;
    dtf    = ntgt - t;
    exp_dt = (dtf > 32'd65535) ? 65535 : int'(dtf);
    chk("dt_req", sio.dt_req, exp_dt);
    chk("time_eq_out", sio.time_eq_out, eq);
    chk("period", sio.period, m_per);
    chk("miss", sio.miss, m_miss);
    // Slice of the sample requested one cycle earlier.
    if (m_pend) begin
      b = (v >= 0);
      if (m_pend_data) begin
        e = (m_prev != b) && (m_edge == m_prev);
        l = (m_prev != b) && (m_edge == b);
        exp_q.push_back('{b: b, e: e, l: l});
        m_le = e;
        m_ll = l;
        m_prev = b;
        m_int = m_int + (e ? 1 : 0) - (l ? 1 : 0);
        if (m_int == KI) begin
          m_int = 0;
          m_per = (m_per - 1 < UMIN) ? UMIN : m_per - 1;
        end else if (m_int == -KI) begin
          m_int = 0;
          m_per = (m_per + 1 > UMAX) ? UMAX : m_per + 1;
        end
      end else begin
        m_edge = b;
      end
    end
    m_pend      = eq;
    m_pend_data = eq && m_data;
    if (eq) m_data = !m_data;
    if (ms) m_miss = 1;
    m_tgt = ntgt;
  endtask

  task automatic hit();
    cycle(m_tgt);
  endtask

  task automatic gap();
    logic [31:0] d;
    d = m_tgt - t_cur;
    if (d > 32'd1 && d < 32'h8000_0000) cycle(t_cur + $urandom_range(1, d - 1));
    else if (d == 32'd0) cycle(t_cur - 32'd1);
    else cycle(t_cur);
  endtask

  task automatic run_events(input int n, input int md);
    int g;
    mode = md;
    for (int i = 0; i < n; i++) begin
      g = (md == 0) ? int'($urandom_range(0, 2)) : 1;
      for (int k = 0; k < g; k++) gap();
      hit();
    end
  endtask

  task automatic apply_reset();
    @(posedge clk_sys);
    #1;
    rst_n = 1'b0;
    sio.time_next = SAFE_T;
    t_cur = SAFE_T;
    model_reset();
    exp_q.delete();
    #3;
    chk("rst_data_bit", sio.data_bit, 0);
    chk("rst_data_valid", sio.data_valid, 0);
    chk("rst_early", sio.early, 0);
    chk("rst_late", sio.late, 0);
    chk("rst_miss", sio.miss, 0);
    chk("rst_period", sio.period, UNOM);
    chk("rst_dt_sat", sio.dt_req, 65535);
    @(posedge clk_sys);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin : monitor
    exp_t ex;
    forever begin
      @(negedge clk_sys);
      if (rst_n) begin
        if (sio.data_valid) begin
          chk("dv_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            ex = exp_q.pop_front();
            chk("data_bit", sio.data_bit, ex.b);
            chk("early", sio.early, ex.e);
            chk("late", sio.late, ex.l);
          end
        end else begin
          chk("strobe_without_valid", sio.early | sio.late, 0);
        end
      end
    end
  end

  initial begin : stimulus
    sio.time_next = SAFE_T;
    sio.in = '0;
    t_cur = SAFE_T;
    mode = 0;
    model_reset();
    #1 rst_n = 1'b0;
    apply_reset();

    cycle(SAFE_T);
    hit();
    run_events(40, 2);
    run_events(1800, 1);
    run_events(300, 0);
    run_events(3400, 3);
    run_events(400, 0);

    mode = 0;
    gap();
    cycle(m_tgt + 32'd3);
    run_events(10, 0);

    cycle(m_tgt + 32'h7FFF_FFFF);
    cycle(32'd10 - 32'(m_per / 2));
    cycle(32'hFFFF_FFFD);
    hit();
    run_events(20, 0);

    for (int i = 0; i < 4 && !m_data; i++) begin
      gap();
      hit();
    end
    gap();
    hit();
    apply_reset();
    cycle(SAFE_T);
    hit();
    run_events(20, 0);

    gap();
    gap();
    gap();
    chk("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
